// File: rtl/grey_decode6_rx.sv
// Receiver for a grey-coded step bus: synchronizes, decodes to binary, and flags
// legal +1 steps (incr) vs illegal jumps (skip_err). Optional macro GREY_RX_ERR_CNT_EN adds err_cnt.
module grey_decode6_rx #(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] grey,
  output logic [WIDTH-1:0] bin,
  output logic             valid,
  output logic             incr,
  output logic             skip_err,
`ifdef GREY_RX_ERR_CNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  localparam int CW = $clog2(SYNC_STAGES + 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_bin;
  logic             r_valid;
  logic             r_incr;
  logic             r_skip;

  logic [WIDTH-1:0] w_s_grey;
  logic [WIDTH-1:0] w_s_bin;
  logic [WIDTH-1:0] w_delta;
  logic             w_step_hit;
  logic             w_skip_hit;

  function automatic logic [WIDTH-1:0] grey_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= grey;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_s_grey = r_sync[SYNC_STAGES-1];
  assign w_s_bin  = grey_to_bin(w_s_grey);

  // Modular difference: 63->0 yields 1 (legal), a backward step yields all-ones (illegal).
  assign w_delta    = w_s_bin - r_bin;
  assign w_step_hit = (r_state == ST_TRACK) && (w_delta == WIDTH'(1));
  assign w_skip_hit = (r_state == ST_TRACK) && (w_delta != '0) && (w_delta != WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_valid <= 1'b0;
      r_incr  <= 1'b0;
      r_skip  <= 1'b0;
    end else begin
      r_incr <= 1'b0;
      r_skip <= 1'b0;
      case (r_state)
        ST_INIT: begin
          // Hold off until the reset-cleared synchronizer has filled with live input.
          if (r_cnt == CW'(SYNC_STAGES - 1)) begin
            r_state <= ST_LOCK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_LOCK: begin
          r_bin   <= w_s_bin;
          r_valid <= 1'b1;
          r_state <= ST_TRACK;
        end
        ST_TRACK: begin
          if (w_delta != '0) begin
            r_bin <= w_s_bin;
          end
          r_incr <= w_step_hit;
          r_skip <= w_skip_hit;
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef GREY_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_skip_hit && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign bin       = r_bin;
  assign valid     = r_valid;
  assign incr      = r_incr;
  assign skip_err  = r_skip;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_grey_decode6_rx.sv
// Bench for grey_decode6_rx: table vectors, hand sequences and random steps checked
// against an integer-count reference model with an expected-pulse queue.
module tb_grey_decode6_rx;
  localparam int W = 6;
  localparam int S = 2;
  localparam int MOD = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] grey = '0;
  logic [W-1:0] bin;
  logic         valid;
  logic         incr;
  logic         skip_err;
  logic [1:0]   dbg_state;
`ifdef GREY_RX_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  grey_decode6_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk),
    .rst(rst),
    .grey(grey),
    .bin(bin),
    .valid(valid),
    .incr(incr),
    .skip_err(skip_err),
`ifdef GREY_RX_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errs   = 0;
  int n_incr   = 0;
  int n_skip   = 0;
  int m_bin    = 0;
  int m_errs   = 0;

  // Expected pulse kinds, in order: 1 = incr, 2 = skip_err.
  logic [1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_grey(input int b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [1:0] got;
    logic [1:0] want;
    if (!rst && (incr || skip_err)) begin
      got  = {skip_err, incr};
      want = (exp_q.size() == 0) ? 2'd0 : exp_q.pop_front();
      check("pulse_kind", int'(got), int'(want));
      if (incr) n_incr++;
      if (skip_err) n_skip++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_step(input int nb, input int hold);
    int d;
    d = ((nb - m_bin) % MOD + MOD) % MOD;
    @(posedge clk);
    #1;
    grey = to_grey(nb);
    if (d == 1) begin
      exp_q.push_back(2'd1);
    end else if (d != 0) begin
      exp_q.push_back(2'd2);
      if (m_errs < 255) m_errs++;
    end
    m_bin = nb % MOD;
    repeat (hold) @(posedge clk);
  endtask

  task automatic settle_check(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_bin"}, int'(bin), m_bin);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_valid"}, int'(valid), 1);
  endtask

  task automatic do_reset(input int relock_bin);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_bin", int'(bin), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_pulses", int'({incr, skip_err}), 0);
`ifdef GREY_RX_ERR_CNT_EN
    check("rst_err_cnt", int'(err_cnt), 0);
`endif
    exp_q.delete();
    grey = to_grey(relock_bin);
    m_bin  = relock_bin;
    m_errs = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (S) @(posedge clk);
    @(negedge clk);
    check("lock_valid_early", int'(valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("lock_valid", int'(valid), 1);
    check("lock_bin", int'(bin), relock_bin);
  endtask

  typedef struct {
    int to_bin;
    int exp_incr;
    int exp_skip;
  } vec_t;

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[10];
    int   i0, s0, old_bin, r, nb;

    vecs[0] = '{1, 1, 0};
    vecs[1] = '{2, 1, 0};
    vecs[2] = '{4, 0, 1};
    vecs[3] = '{5, 1, 0};
    vecs[4] = '{4, 0, 1};
    vecs[5] = '{4, 0, 0};
    vecs[6] = '{63, 0, 1};
    vecs[7] = '{0, 1, 0};
    vecs[8] = '{1, 1, 0};
    vecs[9] = '{0, 0, 1};

    // Test 1: reset with grey held at 0
    do_reset(0);
    repeat (20) @(posedge clk);
    settle_check("idle");
    check("idle_no_pulses", n_incr + n_skip, 0);

    // Test 2: two full laps, one step per 19 clocks
    i0 = n_incr; s0 = n_skip;
    for (int lap = 0; lap < 2; lap++) begin
      for (int k = 0; k < MOD; k++) begin
        drive_step((m_bin + 1) % MOD, 19);
        settle_check("lap");
      end
    end
    check("lap_incr_total", n_incr - i0, 128);
    check("lap_skip_total", n_skip - s0, 0);

    // Tests 3/4: table of skips, backward steps, holds and wrap
    for (int v = 0; v < 10; v++) begin
      i0 = n_incr; s0 = n_skip;
      drive_step(vecs[v].to_bin, 6);
      settle_check("vec");
      check("vec_incr", n_incr - i0, vecs[v].exp_incr);
      check("vec_skip", n_skip - s0, vecs[v].exp_skip);
    end

    // Latency: bin must not move until the third clock after the grey change
    old_bin = m_bin;
    @(posedge clk);
    #1;
    grey = to_grey(old_bin + 1);
    exp_q.push_back(2'd1);
    m_bin = old_bin + 1;
    repeat (S) @(posedge clk);
    @(negedge clk);
    check("lat_bin_before", int'(bin), old_bin);
    @(posedge clk);
    @(negedge clk);
    check("lat_bin_after", int'(bin), old_bin + 1);
    repeat (3) @(posedge clk);
    settle_check("lat");

    // Back-to-back legal steps on consecutive cycles
    i0 = n_incr;
    for (int k = 0; k < 10; k++) drive_step((m_bin + 1) % MOD, 0);
    repeat (6) @(posedge clk);
    settle_check("b2b");
    check("b2b_incr", n_incr - i0, 10);

    // Randomized steps against the model
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7) nb = (m_bin + 1) % MOD;
      else if (r == 7) nb = m_bin;
      else nb = $urandom_range(0, MOD - 1);
      drive_step(nb, $urandom_range(4, 8));
      settle_check("rand");
    end

    // Test 5: reset mid-run at bin 40, relock at 41
    drive_step(40, 6);
    settle_check("pre_rst");
    do_reset(41);
    repeat (10) @(posedge clk);
    settle_check("relock_hold");
    i0 = n_incr;
    drive_step(42, 6);
    settle_check("relock_step");
    check("relock_incr", n_incr - i0, 1);

`ifdef GREY_RX_ERR_CNT_EN
    // Test 6: error counter saturation
    for (int k = 0; k < 300; k++) begin
      drive_step((m_bin + 2) % MOD, 4);
      if (k == 9) begin
        settle_check("errcnt10");
        check("err_cnt_10", int'(err_cnt), m_errs);
      end
    end
    settle_check("errcnt");
    check("err_cnt_sat", int'(err_cnt), 255);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("err_cnt_hold", int'(err_cnt), 255);
    do_reset(m_bin);
`endif

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
